// File: rtl/fp32_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : fp32_divider_if
// Description : Operand/result handshake bundle for the FP32 divider.
//               master = operand sequencer, slave = divider.
// Revision    : 1.0  initial release
// ============================================================================
interface fp32_divider_if;
  logic [31:0] x_data;
  logic [31:0] y_data;
  logic        x_rdy;
  logic        y_rdy;
  logic [31:0] z_data;
  logic        done;
  logic        busy;

  modport master (
    output x_data, y_data, x_rdy, y_rdy,
    input  z_data, done, busy
  );

  modport slave (
    input  x_data, y_data, x_rdy, y_rdy,
    output z_data, done, busy
  );
endinterface
`default_nettype wire

// File: rtl/fp32_divider.sv
`default_nettype none
// ============================================================================
// Module      : fp32_divider
// Description : Multi-cycle IEEE-754 single-precision divider, z = x / y.
//               Restoring mantissa division (one quotient bit per cycle),
//               round-to-nearest-even, gradual underflow.
//               Optional macro FP32_DIV_FTZ_EN: denormal inputs read as zero
//               and tiny results flush to signed zero.
// Revision    : 1.0  initial release
// ============================================================================
module fp32_divider #(
  parameter int DIV_ITERS = 27
) (
  input  logic          clk,
  input  logic          rst_n,
  fp32_divider_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, NORM_X, NORM_Y, DIVIDE,
    NORM_Z, DENORM, ROUND, PACK, DONE
  } state_t;

  localparam logic signed [9:0] c_EMIN     = -10'sd126;
  localparam logic signed [9:0] c_EMAX     = 10'sd127;
  localparam logic signed [9:0] c_BIAS     = 10'sd127;
  localparam logic        [4:0] c_DIV_LAST = 5'(DIV_ITERS - 1);
  localparam logic       [31:0] c_QNAN     = 32'h7FC0_0000;

  state_t state, state_next;

  // Captured operands and unpacked fields
  logic [31:0]        r_x, r_y;
  logic               r_zs;
  logic signed [9:0]  r_xe, r_ye, r_ze;
  logic [23:0]        r_xm, r_ym;
  // Division state
  logic [25:0]        r_rem;
  logic [25:0]        r_q;
  logic [4:0]         r_cnt;
  // Result mantissa with rounding bits
  logic [23:0]        r_zm;
  logic               r_guard, r_round, r_sticky;
  logic               r_special;
  logic [31:0]        r_special_val;
  // Outputs
  logic [31:0]        r_z;
  logic               r_done;

  // Field views of the captured operands
  logic [7:0]  w_x_exp, w_y_exp;
  logic [22:0] w_x_man, w_y_man;
  assign w_x_exp = r_x[30:23];
  assign w_y_exp = r_y[30:23];
  assign w_x_man = r_x[22:0];
  assign w_y_man = r_y[22:0];

  // Operand classification
  logic w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan;
`ifdef FP32_DIV_FTZ_EN
  assign w_x_zero = (w_x_exp == 8'd0);
  assign w_y_zero = (w_y_exp == 8'd0);
`else
  assign w_x_zero = (w_x_exp == 8'd0) && (w_x_man == 23'd0);
  assign w_y_zero = (w_y_exp == 8'd0) && (w_y_man == 23'd0);
`endif
  assign w_x_inf = (w_x_exp == 8'hFF) && (w_x_man == 23'd0);
  assign w_y_inf = (w_y_exp == 8'hFF) && (w_y_man == 23'd0);
  assign w_x_nan = (w_x_exp == 8'hFF) && (w_x_man != 23'd0);
  assign w_y_nan = (w_y_exp == 8'hFF) && (w_y_man != 23'd0);

  logic        w_sign, w_is_nan, w_is_special;
  logic [31:0] w_special_val;
  assign w_sign       = r_x[31] ^ r_y[31];
  assign w_is_nan     = w_x_nan | w_y_nan | (w_x_zero & w_y_zero) | (w_x_inf & w_y_inf);
  assign w_is_special = w_is_nan | w_x_inf | w_y_inf | w_x_zero | w_y_zero;
  assign w_special_val = w_is_nan ? c_QNAN :
                         w_x_inf  ? {w_sign, 8'hFF, 23'd0} :
                         w_y_inf  ? {w_sign, 31'd0} :
                         w_y_zero ? {w_sign, 8'hFF, 23'd0} :
                                    {w_sign, 31'd0};

  // Unbiased exponents; denormals sit at the minimum exponent
  logic signed [9:0] w_xe_unb, w_ye_unb;
  assign w_xe_unb = (w_x_exp == 8'd0) ? c_EMIN : ($signed({2'b00, w_x_exp}) - c_BIAS);
  assign w_ye_unb = (w_y_exp == 8'd0) ? c_EMIN : ($signed({2'b00, w_y_exp}) - c_BIAS);

  // With flush-to-zero no non-zero operand lacks its hidden bit
  logic w_x_norm_done, w_y_norm_done;
`ifdef FP32_DIV_FTZ_EN
  assign w_x_norm_done = 1'b1;
  assign w_y_norm_done = 1'b1;
`else
  assign w_x_norm_done = r_xm[23];
  assign w_y_norm_done = r_ym[23];
`endif

  // One restoring-division step
  logic        w_ge;
  logic [25:0] w_rsub;
  logic [26:0] w_q_next;
  logic        w_div_last;
  assign w_ge       = (r_rem >= {2'b00, r_ym});
  assign w_rsub     = w_ge ? (r_rem - {2'b00, r_ym}) : r_rem;
  assign w_q_next   = {r_q, w_ge};
  assign w_div_last = (r_cnt == c_DIV_LAST);

  logic w_ze_tiny, w_round_up;
  assign w_ze_tiny  = (r_ze < c_EMIN);
  assign w_round_up = r_guard & (r_round | r_sticky | r_zm[0]);

  // Final packing of the rounded result
  logic [7:0]  w_exp_field;
  logic [31:0] w_packed;
  assign w_exp_field = r_ze[7:0] + 8'd127;
  assign w_packed = r_special     ? r_special_val :
                    (r_ze > c_EMAX) ? {r_zs, 8'hFF, 23'd0} :
                    !r_zm[23]     ? {r_zs, 8'h00, r_zm[22:0]} :
                                    {r_zs, w_exp_field, r_zm[22:0]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.x_rdy && bus.y_rdy) state_next = UNPACK;
      UNPACK:  state_next = SPECIAL;
      SPECIAL: state_next = w_is_special ? PACK : NORM_X;
      NORM_X:  if (w_x_norm_done) state_next = NORM_Y;
      NORM_Y:  if (w_y_norm_done) state_next = DIVIDE;
      DIVIDE:  if (w_div_last) state_next = NORM_Z;
      NORM_Z: begin
        if (r_zm[23]) begin
`ifdef FP32_DIV_FTZ_EN
          state_next = w_ze_tiny ? PACK : ROUND;
`else
          state_next = DENORM;
`endif
        end
      end
      DENORM:  if (!w_ze_tiny) state_next = ROUND;
      ROUND:   state_next = PACK;
      PACK:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: each state updates only the registers it owns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= 32'd0;
      r_y           <= 32'd0;
      r_zs          <= 1'b0;
      r_xe          <= 10'sd0;
      r_ye          <= 10'sd0;
      r_ze          <= 10'sd0;
      r_xm          <= 24'd0;
      r_ym          <= 24'd0;
      r_rem         <= 26'd0;
      r_q           <= 26'd0;
      r_cnt         <= 5'd0;
      r_zm          <= 24'd0;
      r_guard       <= 1'b0;
      r_round       <= 1'b0;
      r_sticky      <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= 32'd0;
      r_z           <= 32'd0;
      r_done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.x_rdy && bus.y_rdy) begin
            r_x <= bus.x_data;
            r_y <= bus.y_data;
          end
        end
        UNPACK: begin
          r_zs <= w_sign;
          r_xe <= w_xe_unb;
          r_ye <= w_ye_unb;
          r_xm <= {(w_x_exp != 8'd0), w_x_man};
          r_ym <= {(w_y_exp != 8'd0), w_y_man};
        end
        SPECIAL: begin
          r_special     <= w_is_special;
          r_special_val <= w_special_val;
        end
        NORM_X: begin
          if (!w_x_norm_done) begin
            r_xm <= {r_xm[22:0], 1'b0};
            r_xe <= r_xe - 10'sd1;
          end
        end
        NORM_Y: begin
          if (!w_y_norm_done) begin
            r_ym <= {r_ym[22:0], 1'b0};
            r_ye <= r_ye - 10'sd1;
          end else begin
            r_ze  <= r_xe - r_ye;
            r_rem <= {2'b00, r_xm};
            r_q   <= 26'd0;
            r_cnt <= 5'd0;
          end
        end
        DIVIDE: begin
          r_rem <= {w_rsub[24:0], 1'b0};
          r_q   <= w_q_next[25:0];
          r_cnt <= r_cnt + 5'd1;
          if (w_div_last) begin
            r_zm     <= w_q_next[26:3];
            r_guard  <= w_q_next[2];
            r_round  <= w_q_next[1];
            r_sticky <= w_q_next[0] | (w_rsub != 26'd0);
          end
        end
        NORM_Z: begin
          if (!r_zm[23]) begin
            // Quotient below 1.0: pull the guard bit up into the mantissa
            r_zm    <= {r_zm[22:0], r_guard};
            r_guard <= r_round;
            r_round <= 1'b0;
            r_ze    <= r_ze - 10'sd1;
          end
`ifdef FP32_DIV_FTZ_EN
          else if (w_ze_tiny) begin
            r_special     <= 1'b1;
            r_special_val <= {r_zs, 31'd0};
          end
`endif
        end
        DENORM: begin
          if (w_ze_tiny) begin
            // Shift through guard/round so rounding still sees exact bits
            r_zm     <= {1'b0, r_zm[23:1]};
            r_guard  <= r_zm[0];
            r_round  <= r_guard;
            r_sticky <= r_sticky | r_round;
            r_ze     <= r_ze + 10'sd1;
          end
        end
        ROUND: begin
          if (w_round_up) begin
            if (&r_zm) begin
              r_zm <= 24'h80_0000;
              r_ze <= r_ze + 10'sd1;
            end else begin
              r_zm <= r_zm + 24'd1;
            end
          end
        end
        PACK: begin
          r_z    <= w_packed;
          r_done <= 1'b1;
        end
        DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.z_data = r_z;
  assign bus.done   = r_done;
  assign bus.busy   = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/fp32_divider.md
Name: fp32_divider

Overview:
- Multi-cycle IEEE-754 single-precision divider, z = x / y.
- It is the inverse-operation companion of the feedforward datapath's multi-cycle FP32 multiplier.
- It uses the same operand handshake (x_rdy/y_rdy in, done out) so normalisation stages can share operand sequencing with the multiplier.
- Mantissa division is restoring, one quotient bit per cycle. Rounding is round-to-nearest-even, with denormal support.

Parameters:
- DIV_ITERS, 27, quotient bits generated: 24 mantissa bits plus guard, round and one spare for the post-normalise shift. Fixed; other values are unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- x_data  in  32  dividend, FP32
- y_data  in  32  divisor, FP32
- x_rdy  in  1  dividend valid
- y_rdy  in  1  divisor valid
- z_data  out  32  quotient, FP32; registered; held until the next completion
- done  out  1  one-cycle pulse when z_data updates
- busy  out  1  high from acceptance until the cycle done is high, inclusive

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; z_data=0, done=0, busy=0.
  - An operation in flight is abandoned with no done pulse.
- Acceptance:
  - Occurs on the edge where state=IDLE and x_rdy&y_rdy=1.
  - x_data/y_data are captured into internal registers on that edge; the inputs may change afterwards.
  - Call this edge E0.
- States, one per cycle unless noted:
  - IDLE, UNPACK, SPECIAL, NORM_X, NORM_Y, DIVIDE, NORM_Z, DENORM, ROUND, PACK, DONE.
- UNPACK:
  - Split sign, exponent and mantissa.
  - Exponents are 10-bit signed, unbiased: e−127.
  - Denormal inputs (exp=0) take e=−126 with hidden bit 0; otherwise hidden bit 1.
- SPECIAL: in priority order.
  - Either operand NaN, 0/0, or inf/inf → 32'h7FC00000.
  - x inf → signed inf.
  - y inf → signed zero.
  - y zero → signed inf.
  - x zero → signed zero.
  - Result sign is xs^ys for all cases except NaN.
  - Special results go to PACK.
- NORM_X / NORM_Y: while hidden bit=0, shift the mantissa left and decrement e, one cycle per shift.
- DIVIDE:
  - ze = xe − ye; remainder r = mx, 26 bits.
  - Each cycle: if r ≥ my then q bit=1 and r −= my, else q bit=0; then r <<= 1.
  - Runs DIV_ITERS cycles, producing q[26:0] MSB first.
- NORM_Z:
  - zm = q[26:3], guard = q[2], round = q[1], sticky = q[0] | (r≠0).
  - If zm[23]=0, shift one place left (guard enters the LSB, round moves into guard) and decrement ze. This takes at most one extra cycle.
- DENORM:
  - While ze < −126: shift zm right, increment ze, and OR the bits shifted out into sticky.
  - Each shift is one cycle.
- ROUND:
  - Increment zm if guard & (round|sticky|zm[0]).
  - On carry-out (zm=24'hFFFFFF), set zm=24'h800000 and increment ze.
- PACK:
  - ze > 127 → signed inf.
  - zm[23]=0 after DENORM → exponent field 0 (denormal or zero).
  - Otherwise the exponent field is ze+127.
  - z_data and done are registered on the PACK edge.
- DONE:
  - done=1 for exactly this cycle; busy drops on the next edge; return to IDLE.
  - If x_rdy&y_rdy is still high in IDLE, a new operation is accepted (back-to-back allowed).
- Latency, counted from E0 to the edge registering done:
  - Normal operands, normal result: 35 edges when mx ≥ my, 36 otherwise.
  - Special case: 3 edges.
  - Each input-normalise shift adds 1; each DENORM shift adds 1.

Optional Feature:
- Macro: FP32_DIV_FTZ_EN.
- Defined:
  - Denormal inputs are treated as signed zero in SPECIAL.
  - Results with ze < −126 after NORM_Z are flushed to signed zero.
  - DENORM is skipped, and NORM_X/NORM_Y never iterate.
- Undefined: full gradual-underflow behaviour as above.

Test Plan:
- x=40C00000 (6.0), y=40000000 (2.0) → z_data=40400000; done 35 cycles after acceptance, one cycle wide; busy high throughout.
- x=3F800000, y=40400000 (1/3) → 3EAAAAAB (rounds up), 36-cycle latency.
- Specials:
  - 3F800000/00000000 → 7F800000.
  - BF800000/00000000 → FF800000.
  - 00000000/00000000 → 7FC00000.
  - 7F800000/7F800000 → 7FC00000.
  - Each returns done 3 cycles after acceptance.
- Overflow 7F7FFFFF/3F000000 → 7F800000.
- Underflow to denormal:
  - 00800000/40000000 → 00400000.
  - With FP32_DIV_FTZ_EN: 00000000, and 00400000/3F800000 → 00000000.
- Reset mid-DIVIDE:
  - Drop rst_n at cycle 15 → z_data=0, done=0, busy=0 immediately.
  - After release with rdy held high, a fresh operation completes correctly.
  - Also: change x_data on the cycle after acceptance → result still reflects the captured operands.
